// File: rtl/tms34020_cache_fill.sv
// Bus-side fill engine for the TMS34020 instruction cache: fetches a missing 128-bit subsegment as
// four longwords and presents each on the cache write port with CE_F/CE_R phasing.
module tms34020_cache_fill (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        ce_f_i,
  input  logic        ce_r_i,
  input  logic        rst_exec_i,
  input  logic [31:0] pc_i,
  input  logic        cache_miss_i,
  output logic [31:0] cache_data_o,
  output logic        cache_wr_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_di_i,
  output logic        fill_busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StBus,
    StArm,
    StWrRise,
    StWrFall
  } state_e;

  state_e      state_q;
  logic [24:0] base_q;
  logic [1:0]  start_q;
  logic [1:0]  cnt_q;
  logic [31:0] data_q;
  logic [31:0] cache_data_q;
  logic [31:0] mem_addr_q;
  logic        cache_wr_q;
  logic        mem_req_q;
  logic        busy_q;

  logic [1:0]  cnt_inc;
  logic [1:0]  word_next;

  assign cnt_inc   = cnt_q + 2'd1;
  // Fill order wraps modulo 4 starting at the missed word.
  assign word_next = start_q + cnt_inc;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      base_q       <= '0;
      start_q      <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      cache_data_q <= '0;
      mem_addr_q   <= '0;
      cache_wr_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else if (en_i) begin
      unique case (state_q)
        StIdle: begin
          if (ce_f_i && cache_miss_i && !rst_exec_i) begin
            base_q     <= pc_i[31:7];
            start_q    <= pc_i[6:5];
            cnt_q      <= 2'd0;
            mem_addr_q <= {pc_i[31:5], 5'b0};
            mem_req_q  <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StBus;
          end
        end
        StBus: begin
          if (mem_ack_i) begin
            data_q    <= mem_di_i;
            mem_req_q <= 1'b0;
            state_q   <= StArm;
          end
        end
        StArm: begin
          if (ce_f_i) begin
            cache_wr_q   <= 1'b1;
            cache_data_q <= data_q;
            state_q      <= StWrRise;
          end
        end
        StWrRise: begin
          // The cache latches its write address on this CE_R.
          if (ce_r_i) begin
            state_q <= StWrFall;
          end
        end
        StWrFall: begin
          if (ce_f_i) begin
            cache_wr_q <= 1'b0;
            if (cnt_q == 2'd3) begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end else begin
              cnt_q      <= cnt_inc;
              mem_addr_q <= {base_q, word_next, 5'b0};
              mem_req_q  <= 1'b1;
              state_q    <= StBus;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cache_data_o = cache_data_q;
  assign cache_wr_o   = cache_wr_q;
  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign fill_busy_o  = busy_q;

endmodule

// File: tb/tb_tms34020_cache_fill.sv
// Randomized bench for tms34020_cache_fill: a cycle reference model built from the fill rules plus
// transaction monitors that check address order and written data per fill.
module tb_tms34020_cache_fill;

  logic        clk = 1'b0;
  logic        rst_n, en, ce_f, ce_r, rst_exec, miss, ack;
  logic [31:0] pc, di;
  logic [31:0] cache_data_o, mem_addr_o;
  logic        cache_wr_o, mem_req_o, fill_busy_o;

  always #5 clk = ~clk;

  tms34020_cache_fill u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .ce_f_i       (ce_f),
    .ce_r_i       (ce_r),
    .rst_exec_i   (rst_exec),
    .pc_i         (pc),
    .cache_miss_i (miss),
    .cache_data_o (cache_data_o),
    .cache_wr_o   (cache_wr_o),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (ack),
    .mem_di_i     (di),
    .fill_busy_o  (fill_busy_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Stimulus knobs
  int unsigned en_pct   = 100;
  int unsigned ack_dly  = 0;
  int unsigned spur_pct = 0;
  bit          di_seq   = 1'b0;
  bit          rx_rand  = 1'b0;
  bit          ph       = 1'b1;
  int          ack_wait = 0;
  int          win_r    = 0;

  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] ack_data[$];

  // Reference model state
  bit          m_ok = 1'b0;
  bit          m_active, m_acked, m_open;
  int          m_r, m_word;
  logic [24:0] m_base;
  logic [1:0]  m_start;
  logic [31:0] m_cap, m_wdata, m_addr;
  bit          mon_r = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (m_ok) begin
        m_addr = {m_base, 7'b0} + 32'(((m_start + m_word) % 4) * 32);
        check_val("busy", {31'b0, fill_busy_o}, {31'b0, m_active});
        check_val("req", {31'b0, mem_req_o}, {31'b0, m_active && !m_acked});
        check_val("wr", {31'b0, cache_wr_o}, {31'b0, m_open});
        if (m_active && !m_acked) check_val("addr", mem_addr_o, m_addr);
        if (m_open) check_val("wdata", cache_data_o, m_wdata);
      end
      // Transaction monitor
      if (!rst_n) begin
        mon_r = 1'b0;
      end else if (en) begin
        if (mem_req_o && ack) begin
          got_addr.push_back(mem_addr_o);
          ack_data.push_back(di);
        end
        if (cache_wr_o && ce_r) mon_r = 1'b1;
        else if (cache_wr_o && ce_f && mon_r) begin
          got_data.push_back(cache_data_o);
          mon_r = 1'b0;
        end
      end
      // Advance the model across the coming edge
      if (!rst_n) begin
        m_ok = 1'b1; m_active = 0; m_acked = 0; m_open = 0; m_r = 0; m_word = 0;
        m_base = '0; m_start = '0; m_cap = '0; m_wdata = '0;
      end else if (en) begin
        if (!m_active) begin
          if (ce_f && miss && !rst_exec) begin
            m_active = 1; m_acked = 0; m_word = 0; m_base = pc[31:7]; m_start = pc[6:5];
          end
        end else if (!m_acked) begin
          if (ack) begin m_acked = 1; m_cap = di; end
        end else if (!m_open) begin
          if (ce_f) begin m_open = 1; m_wdata = m_cap; m_r = 0; end
        end else if (ce_r) begin
          m_r++;
        end else if (ce_f && m_r > 0) begin
          m_open = 0;
          if (m_word == 3) m_active = 0;
          else begin m_word++; m_acked = 0; end
        end
      end
    end
  end

  // One clock: models the cache clearing MISS on the 4th window CE_R, then drives new inputs.
  task automatic cycle();
    logic p_en, p_r, p_rst;
    p_en = en; p_r = ce_r; p_rst = rst_n;
    @(posedge clk); #1;
    if (!p_rst) win_r = 0;
    else if (p_en && p_r && cache_wr_o) begin
      win_r++;
      if (win_r == 4) miss = 1'b0;
    end
    ce_f = ph; ce_r = !ph; ph = !ph;
    en = ($urandom_range(99) < en_pct);
    if (mem_req_o) begin
      ack_wait++;
      ack = (ack_wait > int'(ack_dly));
    end else begin
      ack_wait = 0;
      ack = ($urandom_range(99) < spur_pct);
    end
    di = di_seq ? 32'hA0 + 32'(got_addr.size()) : $urandom;
    if (rx_rand && fill_busy_o) rst_exec = $urandom_range(1);
  endtask

  task automatic finish_fill(input int budget, input string tag);
    int i = 0;
    while ((miss || fill_busy_o) && i < budget) begin
      cycle();
      i++;
    end
    check_val(tag, {31'b0, miss | fill_busy_o}, 32'd0);
    miss = 1'b0;
    rst_exec = 1'b0;
  endtask

  task automatic start_miss(input logic [31:0] a);
    got_addr.delete(); got_data.delete(); ack_data.delete();
    pc = a; miss = 1'b1; win_r = 0;
  endtask

  task automatic check_fill(input string tag, input logic [31:0] a, input bit seq);
    check_val({tag, "_naddr"}, 32'(got_addr.size()), 32'd4);
    check_val({tag, "_ndata"}, 32'(got_data.size()), 32'd4);
    for (int k = 0; k < 4 && k < got_addr.size(); k++)
      check_val({tag, "_addr"}, got_addr[k], {a[31:7], 7'b0} + 32'(((a[6:5] + k) % 4) * 32));
    for (int k = 0; k < got_data.size() && k < ack_data.size(); k++)
      check_val({tag, "_data"}, got_data[k], seq ? 32'hA0 + 32'(k) : ack_data[k]);
  endtask

  initial begin
    logic [31:0] a;
    int i;
    rst_n = 0; en = 1; ce_f = 0; ce_r = 1; rst_exec = 0; miss = 1; ack = 0; pc = 32'h1200;
    di = 0;
    // Reset held with a pending miss
    repeat (3) cycle();
    check_val("rst_data", cache_data_o, 32'd0);
    check_val("rst_wr", {31'b0, cache_wr_o}, 32'd0);
    check_val("rst_req", {31'b0, mem_req_o}, 32'd0);
    check_val("rst_addr", mem_addr_o, 32'd0);
    check_val("rst_busy", {31'b0, fill_busy_o}, 32'd0);
    rst_n = 1; miss = 0;
    repeat (10) cycle();
    check_val("idle_busy", {31'b0, fill_busy_o}, 32'd0);

    // Aligned and wrapped fills with immediate acks
    di_seq = 1;
    start_miss(32'h0000_1200); finish_fill(200, "aligned_done");
    check_fill("aligned", 32'h0000_1200, 1'b1);
    repeat (4) cycle();
    start_miss(32'h0000_1260); finish_fill(200, "wrapped_done");
    check_fill("wrapped", 32'h0000_1260, 1'b1);
    di_seq = 0;

    // Slow memory with EN gaps and stray acks
    en_pct = 75; ack_dly = 5; spur_pct = 30;
    a = $urandom;
    start_miss(a); finish_fill(800, "slow_done");
    check_fill("slow", a, 1'b0);

    // RST_EXEC blocks a new fill
    rst_exec = 1; start_miss(32'h0000_4440);
    repeat (20) cycle();
    check_val("rx_busy", {31'b0, fill_busy_o}, 32'd0);
    check_val("rx_nreq", 32'(got_addr.size()), 32'd0);
    miss = 0; rst_exec = 0;
    repeat (4) cycle();
    // RST_EXEC raised after word 1 does not stop the fill
    a = 32'h0000_4440;
    start_miss(a);
    i = 0;
    while (got_data.size() < 1 && i < 400) begin cycle(); i++; end
    rst_exec = 1;
    finish_fill(800, "rx_mid_done");
    check_fill("rx_mid", a, 1'b0);

    // Reset during the second write window
    en_pct = 100; ack_dly = 1;
    a = 32'h00AB_CD20;
    start_miss(a);
    i = 0;
    while (!(got_data.size() == 1 && cache_wr_o) && i < 400) begin cycle(); i++; end
    check_val("mid_reach", {31'b0, cache_wr_o}, 32'd1);
    rst_n = 0; miss = 0;
    cycle();
    check_val("mid_wr", {31'b0, cache_wr_o}, 32'd0);
    check_val("mid_req", {31'b0, mem_req_o}, 32'd0);
    check_val("mid_busy", {31'b0, fill_busy_o}, 32'd0);
    rst_n = 1;
    repeat (3) cycle();
    start_miss(a); finish_fill(400, "post_rst_done");
    check_fill("post_rst", a, 1'b0);

    // Random fills
    rx_rand = 1;
    for (int n = 0; n < 25; n++) begin
      en_pct = $urandom_range(100, 50); ack_dly = $urandom_range(4); spur_pct = $urandom_range(40);
      a = $urandom;
      start_miss(a); finish_fill(1000, "rand_done");
      check_fill("rand", a, 1'b0);
      repeat ($urandom_range(5)) cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
